// File: rtl/lsb_mem_port_pkg.sv
// lsb_mem_port_pkg: opcodes, funct3 codes, FSM encoding and I/O base shared by the LSB memory port
package lsb_mem_port_pkg;
    localparam logic [6:0] LD_TYPE = 7'b0000011;
    localparam logic [6:0] ST_TYPE = 7'b0100011;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;
    function automatic logic [2:0] byte_count(input logic [2:0] f3);
        return f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/mem_load_extend.sv
// mem_load_extend: sign/zero extension of an assembled load word by funct3
// raw: assembled little-endian bytes; f3: load funct3; val: extended result
module mem_load_extend
    import lsb_mem_port_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  f3,
    output logic [31:0] val
);
    always_comb begin
        val = (f3 == F3_W)  ? raw :
              (f3 == F3_B)  ? {{24{raw[7]}}, raw[7:0]} :
              (f3 == F3_H)  ? {{16{raw[15]}}, raw[15:0]} :
              (f3 == F3_BU) ? {24'd0, raw[7:0]} :
              (f3 == F3_HU) ? {16'd0, raw[15:0]} : raw;
    end
endmodule

// File: rtl/lsb_mem_port.sv
// lsb_mem_port: byte-serial load/store port between the LSB and the shared RAM byte port
// clk_in, rst_in: clock and asynchronous active-low reset; rdy_in: global ready, low freezes the block
// rob_clear_up, lsb_visit_mem, op_type_out, op_out, store_addr_out, store_val_in: request from the LSB
// cache_welcome_signal, cache_ready, is_load, load_val_out: response to the LSB
// mem_req, mem_gnt, mem_a, mem_dout, mem_wr, mem_din: arbitrated RAM byte port; io_buffer_full: I/O write backpressure
module lsb_mem_port
    import lsb_mem_port_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic        lsb_visit_mem,
    input  logic [6:0]  op_type_out,
    input  logic [2:0]  op_out,
    input  logic [31:0] store_addr_out,
    input  logic [31:0] store_val_in,
    output logic        cache_welcome_signal,
    output logic        cache_ready,
    output logic        is_load,
    output logic [31:0] load_val_out,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din,
    input  logic        io_buffer_full
);
    state_t      state;
    state_t      state_nxt;
    logic [6:0]  op_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  k;
    logic        cap_vld;
    logic [1:0]  cap_lane;
    logic        flush_sup;
    logic        is_ld;
    logic        is_st;
    logic        accept;
    logic        io_stall;
    logic        adv;
    logic        last_byte;
    logic [31:0] data_mrg;
    logic [31:0] ext_val;

    mem_load_extend u_ext (
        .raw(data_mrg),
        .f3 (f3_q),
        .val(ext_val)
    );

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in)
            state <= IDLE;
        else
            state <= state_nxt;

    // data_mrg folds the byte returned for the previous granted read into its lane,
    // so the final load byte reaches the extender in the same cycle it arrives
    always_comb begin
        is_ld = op_q == LD_TYPE;
        is_st = op_q == ST_TYPE;
        accept = rdy_in && !rob_clear_up && lsb_visit_mem;
        mem_a = (state == XFER) ? addr_q + {29'd0, k} : 32'd0;
        io_stall = is_st && mem_a >= IO_BASE && io_buffer_full;
        adv = state == XFER && mem_gnt && !io_stall;
        last_byte = k + 3'd1 == byte_count(f3_q);
        mem_req = rdy_in && state == XFER;
        mem_wr = mem_req && is_st && mem_gnt && !io_stall;
        mem_dout = (state == XFER && is_st) ? data_q[{k[1:0], 3'b000} +: 8] : 8'd0;
        cache_welcome_signal = state == IDLE;
        cache_ready = rdy_in && state == DONE && !flush_sup;
        is_load = state == DONE && is_ld;
        data_mrg = data_q;
        if (cap_vld)
            data_mrg[{cap_lane, 3'b000} +: 8] = mem_din;
        state_nxt = state;
        if (rdy_in)
            case (state)
                IDLE:    state_nxt = accept ? XFER : IDLE;
                XFER:    state_nxt = (rob_clear_up && is_ld) ? IDLE :
                                     (adv && last_byte) ? (is_ld ? LAST : DONE) : XFER;
                LAST:    state_nxt = rob_clear_up ? IDLE : DONE;
                default: state_nxt = IDLE;
            endcase
    end

    // a flushed store still drains every byte; flush_sup only silences its completion pulse
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            op_q <= '0;
            f3_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            k <= '0;
            cap_vld <= 1'b0;
            cap_lane <= '0;
            flush_sup <= 1'b0;
            load_val_out <= '0;
        end else if (rdy_in) begin
            cap_vld <= adv && is_ld;
            cap_lane <= k[1:0];
            if (state == IDLE && accept) begin
                op_q <= op_type_out;
                f3_q <= op_out;
                addr_q <= store_addr_out;
                data_q <= store_val_in;
                k <= '0;
                flush_sup <= 1'b0;
            end
            if (state == XFER || state == LAST)
                data_q <= data_mrg;
            if (adv)
                k <= k + 3'd1;
            if (state == XFER && rob_clear_up && is_st)
                flush_sup <= 1'b1;
            if (state == LAST && !rob_clear_up)
                load_val_out <= ext_val;
            if (state == DONE)
                flush_sup <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsb_mem_port.sv
// tb_lsb_mem_port: vector table, corner sequences and random traffic against a byte-RAM reference
module tb_lsb_mem_port;
    import lsb_mem_port_pkg::*;
    localparam int MAXC = 40;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic        rob_clear_up = 1'b0;
    logic        lsb_visit_mem = 1'b0;
    logic [6:0]  op_type_out = '0;
    logic [2:0]  op_out = '0;
    logic [31:0] store_addr_out = '0;
    logic [31:0] store_val_in = '0;
    logic        cache_welcome_signal;
    logic        cache_ready;
    logic        is_load;
    logic [31:0] load_val_out;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din = '0;
    logic        io_buffer_full = 1'b0;

    lsb_mem_port dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
        .lsb_visit_mem(lsb_visit_mem), .op_type_out(op_type_out), .op_out(op_out),
        .store_addr_out(store_addr_out), .store_val_in(store_val_in),
        .cache_welcome_signal(cache_welcome_signal), .cache_ready(cache_ready),
        .is_load(is_load), .load_val_out(load_val_out), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0]  ram [0:262143];
    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    bit          g_gnt [1:MAXC];
    bit          g_full [1:MAXC];
    bit          g_fl [1:MAXC];
    bit          g_rdy [1:MAXC];
    bit          g_rst [1:MAXC];
    logic        tr_req [1:MAXC];
    logic        tr_wr [1:MAXC];
    logic        tr_wel [1:MAXC];
    logic        tr_cr [1:MAXC];
    logic [31:0] tr_a [1:MAXC];
    logic [7:0]  tr_dout [1:MAXC];

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] val;
        int          cyc;
        logic [31:0] lv;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b10) ? 4 : (f3[1:0] == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] raw = 0;
        int n = nbytes(f3);
        for (int i = 0; i < n; i++)
            raw = raw | (32'(ram[18'(a + 32'(i))]) << (8 * i));
        case (f3)
            3'b000:  return (raw[7] ? 32'hFFFF_FF00 : 32'h0) | raw;
            3'b001:  return (raw[15] ? 32'hFFFF_0000 : 32'h0) | raw;
            default: return raw;
        endcase
    endfunction

    // cycle (counted from the accept edge) in which cache_ready is expected, 0 if never
    function automatic int exp_cycle(input bit ld, input int n, input bit io);
        int got = 0;
        int ph = 0;
        bit sup = 0;
        for (int c = 1; c <= MAXC; c++) begin
            if (g_rst[c])
                return 0;
            if (g_rdy[c]) begin
                if (ph == 2)
                    return sup ? 0 : c;
                if (g_fl[c] && ld)
                    return 0;
                if (g_fl[c])
                    sup = 1;
                if (ph == 1)
                    ph = 2;
                else if (g_gnt[c] && !(io && !ld && g_full[c])) begin
                    got++;
                    if (got == n)
                        ph = ld ? 1 : 2;
                end
            end
        end
        return 0;
    endfunction

    task automatic set_defaults();
        for (int c = 1; c <= MAXC; c++) begin
            g_gnt[c] = 1;
            g_full[c] = 0;
            g_fl[c] = 0;
            g_rdy[c] = 1;
            g_rst[c] = 0;
        end
    endtask

    // issues one request, plays the RAM side from the g_* schedules and records per-cycle traces
    task automatic do_txn(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] val, output int cyc, output logic [31:0] lv, output logic il);
        logic rd_pend = 0;
        logic [31:0] rd_a = 0;
        cyc = 0;
        lv = 0;
        il = 0;
        for (int c = 1; c <= MAXC; c++) begin
            tr_req[c] = 0; tr_wr[c] = 0; tr_wel[c] = 0; tr_cr[c] = 0; tr_a[c] = 0; tr_dout[c] = 0;
        end
        @(negedge clk_in);
        rdy_in = 1; rob_clear_up = 0; mem_gnt = 0; io_buffer_full = 0;
        lsb_visit_mem = 1; op_type_out = opc; op_out = f3; store_addr_out = addr; store_val_in = val;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk_in);
            if (rd_pend)
                mem_din = ram[rd_a[17:0]];
            rd_pend = 0;
            mem_gnt = g_gnt[c]; io_buffer_full = g_full[c]; rob_clear_up = g_fl[c];
            rdy_in = g_rdy[c]; rst_in = !g_rst[c];
            if (g_fl[c] || g_rst[c])
                lsb_visit_mem = 0;
            #1;
            tr_req[c] = mem_req; tr_wr[c] = mem_wr; tr_wel[c] = cache_welcome_signal;
            tr_cr[c] = cache_ready; tr_a[c] = mem_a; tr_dout[c] = mem_dout;
            if (mem_req && mem_gnt) begin
                if (mem_wr) begin
                    ram[mem_a[17:0]] = mem_dout;
                    wr_cnt++;
                end else begin
                    rd_pend = 1;
                    rd_a = mem_a;
                end
            end
            if (cache_ready) begin
                cyc = c; lv = load_val_out; il = is_load; lsb_visit_mem = 0;
                break;
            end
        end
        mem_gnt = 0; io_buffer_full = 0; rob_clear_up = 0; rdy_in = 1; rst_in = 1; lsb_visit_mem = 0;
    endtask

    int          cyc;
    int          w0;
    int          n;
    logic [31:0] lv;
    logic        il;
    logic [31:0] a;
    logic [31:0] v;
    logic [31:0] e;
    logic [2:0]  f3;
    bit          st;
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    initial begin
        for (int i = 0; i < 262144; i++)
            ram[i] = 8'h00;
        ram[18'h100] = 8'h78; ram[18'h101] = 8'h56; ram[18'h102] = 8'h34;
        ram[18'h103] = 8'hF2; ram[18'h104] = 8'h11; ram[18'h200] = 8'h80;
        for (int i = 18'h400; i < 18'h510; i++)
            ram[i] = 8'($urandom);
        set_defaults();
        #3;
        chk("rst_welcome", cache_welcome_signal, 1);
        chk("rst_ready", cache_ready, 0);
        chk("rst_is_load", is_load, 0);
        chk("rst_load_val", load_val_out, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", mem_dout, 0);
        @(negedge clk_in);
        rst_in = 1; rdy_in = 1;

        tbl[0] = '{LD_TYPE, 3'b010, 32'h100, 32'h0, 6, 32'hF234_5678};
        tbl[1] = '{LD_TYPE, 3'b000, 32'h200, 32'h0, 3, 32'hFFFF_FF80};
        tbl[2] = '{LD_TYPE, 3'b100, 32'h200, 32'h0, 3, 32'h0000_0080};
        tbl[3] = '{LD_TYPE, 3'b001, 32'h102, 32'h0, 4, 32'hFFFF_F234};
        tbl[4] = '{LD_TYPE, 3'b101, 32'h102, 32'h0, 4, 32'h0000_F234};
        tbl[5] = '{LD_TYPE, 3'b010, 32'h101, 32'h0, 6, 32'h11F2_3456};
        tbl[6] = '{LD_TYPE, 3'b001, 32'h100, 32'h0, 4, 32'h0000_5678};
        tbl[7] = '{ST_TYPE, 3'b010, 32'h140, 32'hA1B2_C3D4, 5, 32'h0};
        tbl[8] = '{ST_TYPE, 3'b000, 32'h150, 32'h0000_005A, 2, 32'h0};
        tbl[9] = '{ST_TYPE, 3'b001, 32'h152, 32'h1234_9876, 3, 32'h0};
        for (int t = 0; t < 10; t++) begin
            w0 = wr_cnt;
            n = nbytes(tbl[t].f3);
            do_txn(tbl[t].opc, tbl[t].f3, tbl[t].addr, tbl[t].val, cyc, lv, il);
            chk($sformatf("tbl%0d_cycle", t), cyc, tbl[t].cyc);
            chk($sformatf("tbl%0d_is_load", t), il, tbl[t].opc == LD_TYPE);
            if (tbl[t].opc == LD_TYPE) begin
                chk($sformatf("tbl%0d_load_val", t), lv, tbl[t].lv);
                chk($sformatf("tbl%0d_no_writes", t), wr_cnt - w0, 0);
            end else begin
                chk($sformatf("tbl%0d_writes", t), wr_cnt - w0, n);
                for (int i = 0; i < n; i++)
                    chk($sformatf("tbl%0d_byte%0d", t, i), ram[18'(tbl[t].addr + 32'(i))], 8'(tbl[t].val >> (8 * i)));
                chk($sformatf("tbl%0d_no_spill", t), ram[18'(tbl[t].addr + 32'(n))], 0);
            end
        end

        g_gnt[2] = 0;
        do_txn(ST_TYPE, 3'b001, 32'h301, 32'h0000_BEEF, cyc, lv, il);
        chk("sh_gnt_wr1", tr_wr[1], 1);
        chk("sh_gnt_a1", tr_a[1], 32'h301);
        chk("sh_gnt_d1", tr_dout[1], 8'hEF);
        chk("sh_gnt_req2", tr_req[2], 1);
        chk("sh_gnt_wr2", tr_wr[2], 0);
        chk("sh_gnt_wr3", tr_wr[3], 1);
        chk("sh_gnt_a3", tr_a[3], 32'h302);
        chk("sh_gnt_d3", tr_dout[3], 8'hBE);
        chk("sh_gnt_cycle", cyc, exp_cycle(0, 2, 0));
        chk("sh_gnt_ram301", ram[18'h301], 8'hEF);
        chk("sh_gnt_ram302", ram[18'h302], 8'hBE);
        set_defaults();

        g_full[1] = 1; g_full[2] = 1; g_full[3] = 1;
        w0 = wr_cnt;
        do_txn(ST_TYPE, 3'b000, 32'h0003_0000, 32'h0000_0041, cyc, lv, il);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("io_full_wr%0d", c), tr_wr[c], 0);
            chk($sformatf("io_full_req%0d", c), tr_req[c], 1);
        end
        chk("io_wr4", tr_wr[4], 1);
        chk("io_a4", tr_a[4], 32'h0003_0000);
        chk("io_d4", tr_dout[4], 8'h41);
        chk("io_writes", wr_cnt - w0, 1);
        chk("io_cycle", cyc, exp_cycle(0, 1, 1));
        chk("io_cycle_abs", cyc, 5);
        set_defaults();

        g_fl[2] = 1;
        do_txn(LD_TYPE, 3'b010, 32'h100, 32'h0, cyc, lv, il);
        chk("flush_lw_no_ready", cyc, 0);
        chk("flush_lw_idle", tr_wel[3], 1);
        chk("flush_lw_req_off", tr_req[3], 0);
        w0 = wr_cnt;
        do_txn(ST_TYPE, 3'b010, 32'h160, 32'h1122_3344, cyc, lv, il);
        chk("flush_sw_no_ready", cyc, exp_cycle(0, 4, 0));
        chk("flush_sw_writes", wr_cnt - w0, 4);
        chk("flush_sw_word", {ram[18'h163], ram[18'h162], ram[18'h161], ram[18'h160]}, 32'h1122_3344);
        chk("flush_sw_done_busy", tr_wel[5], 0);
        chk("flush_sw_done_cr", tr_cr[5], 0);
        chk("flush_sw_idle", tr_wel[6], 1);
        set_defaults();

        @(negedge clk_in);
        lsb_visit_mem = 1; rob_clear_up = 1; op_type_out = LD_TYPE; op_out = 3'b010; store_addr_out = 32'h100;
        @(negedge clk_in);
        #1;
        chk("idle_flush_welcome", cache_welcome_signal, 1);
        chk("idle_flush_req", mem_req, 0);
        lsb_visit_mem = 0; rob_clear_up = 0;

        g_rst[3] = 1;
        w0 = wr_cnt;
        do_txn(ST_TYPE, 3'b010, 32'h170, 32'h5566_7788, cyc, lv, il);
        chk("rst_mid_req", tr_req[3], 0);
        chk("rst_mid_wr", tr_wr[3], 0);
        chk("rst_mid_a", tr_a[3], 0);
        chk("rst_mid_dout", tr_dout[3], 0);
        chk("rst_mid_welcome", tr_wel[3], 1);
        chk("rst_mid_writes", wr_cnt - w0, 2);
        chk("rst_mid_no_byte2", ram[18'h172], 0);
        chk("rst_mid_no_ready", cyc, 0);
        set_defaults();
        do_txn(LD_TYPE, 3'b010, 32'h100, 32'h0, cyc, lv, il);
        chk("post_rst_lw_cycle", cyc, 6);
        chk("post_rst_lw_val", lv, 32'hF234_5678);

        g_rdy[2] = 0; g_rdy[6] = 0; g_rdy[8] = 0;
        do_txn(LD_TYPE, 3'b010, 32'h100, 32'h0, cyc, lv, il);
        chk("rdy_freeze_req", tr_req[2], 0);
        chk("rdy_freeze_ready", tr_cr[8], 0);
        chk("rdy_freeze_cycle", cyc, exp_cycle(1, 4, 0));
        chk("rdy_freeze_val", lv, 32'hF234_5678);
        set_defaults();

        for (int t = 0; t < 60; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            a = 32'h400 + 32'($urandom_range(0, 255));
            v = $urandom;
            n = nbytes(f3);
            for (int c = 1; c <= MAXC; c++) begin
                g_gnt[c] = $urandom_range(0, 9) < 7;
                g_rdy[c] = $urandom_range(0, 9) < 9;
            end
            e = ref_load(f3, a);
            w0 = wr_cnt;
            do_txn(st ? ST_TYPE : LD_TYPE, f3, a, v, cyc, lv, il);
            chk($sformatf("rnd%0d_cycle", t), cyc, exp_cycle(!st, n, 0));
            chk($sformatf("rnd%0d_is_load", t), il, !st);
            if (st) begin
                chk($sformatf("rnd%0d_writes", t), wr_cnt - w0, n);
                for (int i = 0; i < n; i++)
                    chk($sformatf("rnd%0d_byte%0d", t, i), ram[18'(a + 32'(i))], 8'(v >> (8 * i)));
            end else begin
                chk($sformatf("rnd%0d_load_val", t), lv, e);
            end
            set_defaults();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsb_mem_port.md
LSB_MEM_PORT -- requirements
Module: lsb_mem_port

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0003_0000; addresses >= IO_BASE are memory-mapped I/O.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk_in  in  1  system clock, rising edge.
REQ-004 rst_in  in  1  asynchronous active-low reset.
REQ-005 rdy_in  in  1  global ready; low freezes the block.
REQ-006 rob_clear_up  in  1  pipeline flush.
REQ-007 lsb_visit_mem  in  1  LSB request valid, held until cache_ready.
REQ-008 op_type_out  in  7  opcode: 7'b0000011 load, 7'b0100011 store.
REQ-009 op_out  in  3  funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB/SH/SW 000/001/010.
REQ-010 store_addr_out  in  32  effective address.
REQ-011 store_val_in  in  32  store data.
REQ-012 cache_welcome_signal  out  1  ready to accept a request.
REQ-013 cache_ready  out  1  one-cycle completion pulse.
REQ-014 is_load  out  1  completed op was a load, valid with cache_ready.
REQ-015 load_val_out  out  32  extended load result, valid with cache_ready.
REQ-016 mem_req  out  1  request for the shared RAM byte port.
REQ-017 mem_gnt  in  1  arbiter grant for the current cycle.
REQ-018 mem_a  out  32  byte address.
REQ-019 mem_dout  out  8  write byte.
REQ-020 mem_wr  out  1  1 write, 0 read.
REQ-021 mem_din  in  8  read byte, valid the cycle after a granted read.
REQ-022 io_buffer_full  in  1  I/O write buffer full.

Function
REQ-023 States SHALL be IDLE, XFER, LAST, DONE.
REQ-024 cache_welcome_signal SHALL equal (state==IDLE).
REQ-025 In IDLE, a rising edge with rdy_in=1, rob_clear_up=0 and lsb_visit_mem=1 SHALL latch op, funct3, address and data, clear the byte counter k, and enter XFER.
REQ-026 Byte count n SHALL be 1/2/4 from funct3[1:0].
REQ-027 In XFER, mem_req SHALL be 1; mem_a SHALL be addr+k (32-bit wrap); k SHALL advance only in cycles with mem_gnt=1.
REQ-028 Store XFER: mem_wr=mem_gnt; mem_dout=data[8k+7:8k]; when the address >= IO_BASE and io_buffer_full=1, mem_wr=0 and k SHALL hold.
REQ-029 Load XFER: mem_wr=0; the byte granted at k SHALL be captured from mem_din into byte lane k on the following edge.
REQ-030 After the last granted byte, a store SHALL go to DONE and a load SHALL go to LAST (final capture cycle, mem_req=0), then to DONE.
REQ-031 DONE SHALL last exactly one cycle with cache_ready=1, then return to IDLE.
REQ-032 is_load SHALL be 1 in DONE for loads only.
REQ-033 load_val_out SHALL be sign-extended for LB/LH and zero-extended for LBU/LHU, and SHALL hold its value outside DONE.
REQ-034 With continuous grant, latency from the accept edge SHALL be: LW cache_ready in cycle 6, LB in cycle 3, SW in cycle 5, SB in cycle 2.
REQ-035 Misaligned addresses SHALL be legal, as the port is byte-serial.
REQ-036 A flush during XFER or LAST of a load SHALL return to IDLE immediately with no cache_ready.
REQ-037 A flush during a store SHALL NOT abort it: the store completes all bytes and passes through DONE with cache_ready forced to 0.
REQ-038 A flush in IDLE SHALL block acceptance on that edge.
REQ-039 When rdy_in=0, all state SHALL freeze, and mem_req, mem_wr and cache_ready SHALL be forced to 0.
REQ-040 Outside XFER, mem_req=0, mem_wr=0, mem_a=0 and mem_dout=0.

Reset
REQ-041 When rst_in=0, the block SHALL asynchronously enter IDLE with k=0, cache_ready=0, is_load=0, load_val_out=0, mem_req=0, mem_wr=0, mem_a=0, mem_dout=0, the flush-suppress flag cleared and all latched fields cleared.
REQ-042 Reset mid-transaction SHALL abandon the transaction with no further memory writes.

Structure
REQ-043 Opcodes LD_TYPE/ST_TYPE, funct3 codes, the state encoding and IO_BASE SHALL live in the shared constants file.
REQ-044 Sign/zero extension SHALL be one combinational sub-module, mem_load_extend.

Verification
REQ-045 LW at 0x100 with RAM 0x100..0x103 = 78,56,34,F2 and constant grant -> cache_ready in cycle 6, is_load=1, load_val_out=0xF2345678.
REQ-046 LB then LBU at 0x200 (byte 0x80) -> 0xFFFFFF80, then 0x00000080.
REQ-047 SH 0xBEEF at 0x301 with mem_gnt toggling 1,0,1 -> writes EF@0x301 and BE@0x302 only on granted cycles, then cache_ready.
REQ-048 SB 0x41 at 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write, then cache_ready.
REQ-049 Flush in cycle 2 of an LW -> IDLE next cycle, no cache_ready; the same flush during an SW -> all 4 bytes written, cache_ready stays 0.
REQ-050 rst_in asserted low mid-SW -> outputs cleared immediately; the next LW completes correctly.
